// File: rtl/uncached_data_bridge_if.sv
// uncached_data_bridge_if: request/response channel shared by the CPU side and the uncached bus side
interface uncached_data_bridge_if;
  logic req;
  logic wr;
  logic [1:0] size;
  logic [31:0] addr;
  logic [3:0] wstrb;
  logic [31:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [31:0] rdata;
  logic err;
  modport master(output req, wr, size, addr, wstrb, wdata, input addr_ok, data_ok, rdata, err);
  modport slave(input req, wr, size, addr, wstrb, wdata, output addr_ok, data_ok, rdata, err);
endinterface

// File: rtl/uncached_data_bridge.sv
// uncached_data_bridge: queues CPU data requests in order and issues them one at a time to the uncached bus
module uncached_data_bridge #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  input logic flush,
  uncached_data_bridge_if.slave data,
  uncached_data_bridge_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic wr;
    logic [1:0] size;
    logic [31:0] addr;
    logic [3:0] wstrb;
    logic [31:0] wdata;
  } reqT;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} stateT;
  stateT state, nextState;
  reqT fifo [DEPTH];
  reqT issue;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic drop, full, empty, push, pop, respond, dataOk, dataErr;
  logic [31:0] dataRdata;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign data.addr_ok = !full && !flush && !rst;
  assign push = data.req && data.addr_ok;
  assign pop = state == IDLE && !empty && !flush;
  // A flush landing with the bus response kills that response too
  assign respond = state == WAIT && bus.data_ok && !drop && !flush;
  always_comb begin
    nextState = state;
    nextState = (state == IDLE && pop) ? REQ :
                (state == REQ && bus.addr_ok) ? WAIT :
                (state == WAIT && bus.data_ok) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wrPtr] <= {data.wr, data.size, data.addr, data.wstrb, data.wdata};
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) issue <= '0;
    else if (pop) issue <= fifo[rdPtr];
  end
  // The issued request is never withdrawn; drop swallows its response instead
  always_ff @(posedge clk) begin
    if (rst) drop <= 1'b0;
    else if (state == WAIT && bus.data_ok) drop <= 1'b0;
    else if (flush && state != IDLE) drop <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOk <= 1'b0;
      dataErr <= 1'b0;
      dataRdata <= '0;
    end else begin
      dataOk <= respond;
      dataErr <= respond && bus.err;
      if (respond && !issue.wr) dataRdata <= bus.rdata;
    end
  end
  assign data.data_ok = dataOk;
  assign data.err = dataErr;
  assign data.rdata = dataRdata;
  assign bus.req = state == REQ;
  assign bus.wr = issue.wr;
  assign bus.size = issue.size;
  assign bus.addr = issue.addr;
  assign bus.wstrb = issue.wstrb;
  assign bus.wdata = issue.wdata;
endmodule

// File: tb/tb_uncached_data_bridge.sv
// tb_uncached_data_bridge: directed vector table plus hand-written flush/reset/back-to-back sequences
module tb_uncached_data_bridge;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  int checks = 0;
  int errors = 0;
  uncached_data_bridge_if data();
  uncached_data_bridge_if bus();
  uncached_data_bridge #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .flush(flush), .data(data), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic req;
    logic [31:0] addr;
    logic bao;
    logic bdo;
    logic [31:0] brd;
    logic berr;
    logic eAddrOk;
    logic eBusReq;
    logic [31:0] eBusAddr;
    logic eDok;
    logic [31:0] eRdata;
    logic eErr;
  } vecT;
  vecT vec [12];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic nextCycle();
    @(posedge clk);
    #1;
    data.req = 0;
    flush = 0;
    bus.addr_ok = 0;
    bus.data_ok = 0;
    bus.err = 0;
  endtask
  task automatic cpuReq(logic wr, logic [31:0] addr, logic [3:0] strb, logic [31:0] wd);
    data.req = 1;
    data.wr = wr;
    data.addr = addr;
    data.wstrb = strb;
    data.wdata = wd;
    data.size = 2'd2;
  endtask
  task automatic busTxn(string name, logic [31:0] expAddr, logic expWr, logic [3:0] expStrb,
                        int stall, logic [31:0] rd, logic er, logic [31:0] expRd);
    int n = 0;
    while (!bus.req && n < 20) begin
      nextCycle();
      #3;
      n++;
    end
    check({name, " bus_req"}, 32'(bus.req), 1);
    check({name, " bus_addr"}, bus.addr, expAddr);
    check({name, " bus_wr"}, 32'(bus.wr), 32'(expWr));
    check({name, " bus_wstrb"}, 32'(bus.wstrb), 32'(expStrb));
    repeat (stall) begin
      nextCycle();
      #3;
    end
    check({name, " held"}, {31'(bus.addr), bus.req}, {31'(expAddr), 1'b1});
    bus.addr_ok = 1;
    nextCycle();
    bus.data_ok = 1;
    bus.rdata = rd;
    bus.err = er;
    #3;
    check({name, " early data_ok"}, 32'(data.data_ok), 0);
    nextCycle();
    #3;
    check({name, " data_ok"}, 32'(data.data_ok), 1);
    check({name, " rdata"}, data.rdata, expRd);
    check({name, " err"}, 32'(data.err), 32'(er));
    nextCycle();
    #3;
    check({name, " pulse end"}, 32'(data.data_ok), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    vec[0]  = '{1, 32'h1FC00010, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vec[2]  = '{0, 0, 1, 0, 0, 0, 1, 1, 32'h1FC00010, 0, 0, 0};
    vec[3]  = '{0, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF, 0};
    vec[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0};
    vec[6]  = '{1, 32'h00000100, 0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0};
    vec[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0};
    vec[8]  = '{0, 0, 1, 0, 0, 0, 1, 1, 32'h00000100, 0, 32'hDEADBEEF, 0};
    vec[9]  = '{0, 0, 0, 1, 32'h12345678, 1, 1, 0, 0, 0, 32'hDEADBEEF, 0};
    vec[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h12345678, 1};
    vec[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h12345678, 0};
    data.req = 0;
    data.wr = 0;
    data.size = 2'd2;
    data.addr = 0;
    data.wstrb = 0;
    data.wdata = 0;
    bus.addr_ok = 0;
    bus.data_ok = 0;
    bus.rdata = 0;
    bus.err = 0;
    nextCycle();
    rst = 1;
    nextCycle();
    rst = 1;
    #3;
    check("reset addr_ok", 32'(data.addr_ok), 0);
    check("reset bus_req", 32'(bus.req), 0);
    check("reset data_ok", 32'(data.data_ok), 0);
    check("reset rdata", data.rdata, 0);
    check("reset err", 32'(data.err), 0);
    check("reset bus_addr", bus.addr, 0);
    nextCycle();
    rst = 0;
    #3;
    check("post-reset addr_ok", 32'(data.addr_ok), 1);
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      cpuReq(0, vec[i].addr, 0, 0);
      data.req = vec[i].req;
      bus.addr_ok = vec[i].bao;
      bus.data_ok = vec[i].bdo;
      bus.rdata = vec[i].brd;
      bus.err = vec[i].berr;
      #3;
      check($sformatf("vec%0d addr_ok", i), 32'(data.addr_ok), 32'(vec[i].eAddrOk));
      check($sformatf("vec%0d bus_req", i), 32'(bus.req), 32'(vec[i].eBusReq));
      if (vec[i].eBusReq) check($sformatf("vec%0d bus_addr", i), bus.addr, vec[i].eBusAddr);
      check($sformatf("vec%0d data_ok", i), 32'(data.data_ok), 32'(vec[i].eDok));
      check($sformatf("vec%0d rdata", i), data.rdata, vec[i].eRdata);
      check($sformatf("vec%0d err", i), 32'(data.err), 32'(vec[i].eErr));
    end
    // back-to-back: A, B(store), C with the bus stalling
    nextCycle();
    cpuReq(0, 32'h000000A0, 0, 0);
    #3;
    check("b2b accept A", 32'(data.addr_ok), 1);
    nextCycle();
    cpuReq(1, 32'h000000B0, 4'b0011, 32'h0000ABCD);
    #3;
    check("b2b accept B", 32'(data.addr_ok), 1);
    nextCycle();
    cpuReq(0, 32'h000000C0, 0, 0);
    #3;
    check("b2b accept C", 32'(data.addr_ok), 1);
    nextCycle();
    #3;
    check("b2b full addr_ok", 32'(data.addr_ok), 0);
    busTxn("b2b A", 32'h000000A0, 0, 0, 5, 32'h11111111, 0, 32'h11111111);
    busTxn("b2b B", 32'h000000B0, 1, 4'b0011, 0, 32'h22222222, 0, 32'h11111111);
    busTxn("b2b C", 32'h000000C0, 0, 0, 0, 32'h33333333, 0, 32'h33333333);
    // flush while a load waits on the bus with two more queued
    nextCycle();
    cpuReq(0, 32'h00000300, 0, 0);
    nextCycle();
    cpuReq(0, 32'h00000304, 0, 0);
    nextCycle();
    cpuReq(0, 32'h00000308, 0, 0);
    bus.addr_ok = 1;
    #3;
    check("fw bus_req", 32'(bus.req), 1);
    nextCycle();
    flush = 1;
    #3;
    check("fw flush blocks accept", 32'(data.addr_ok), 0);
    nextCycle();
    #3;
    check("fw fifo empty addr_ok", 32'(data.addr_ok), 1);
    check("fw bus_req low", 32'(bus.req), 0);
    nextCycle();
    bus.data_ok = 1;
    bus.rdata = 32'h77777777;
    #3;
    nextCycle();
    #3;
    check("fw dropped data_ok", 32'(data.data_ok), 0);
    check("fw rdata kept", data.rdata, 32'h33333333);
    n = 0;
    repeat (6) begin
      nextCycle();
      #3;
      if (bus.req) n++;
    end
    check("fw no reissue", 32'(n), 0);
    // flush coincident with the bus response
    nextCycle();
    cpuReq(0, 32'h00000400, 0, 0);
    nextCycle();
    nextCycle();
    bus.addr_ok = 1;
    #3;
    check("fc bus_req", 32'(bus.req), 1);
    nextCycle();
    bus.data_ok = 1;
    bus.rdata = 32'h88888888;
    flush = 1;
    #3;
    nextCycle();
    cpuReq(0, 32'h00000500, 0, 0);
    #3;
    check("fc no data_ok", 32'(data.data_ok), 0);
    check("fc rdata kept", data.rdata, 32'h33333333);
    check("fc accept next", 32'(data.addr_ok), 1);
    nextCycle();
    #3;
    check("fc idle pop cycle", 32'(bus.req), 0);
    nextCycle();
    #3;
    check("fc reissue latency", 32'(bus.req), 1);
    busTxn("fc Q", 32'h00000500, 0, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D);
    // reset while a request is on the bus
    nextCycle();
    cpuReq(0, 32'h00000600, 0, 0);
    nextCycle();
    cpuReq(0, 32'h00000604, 0, 0);
    nextCycle();
    #3;
    check("rr bus_req before reset", 32'(bus.req), 1);
    rst = 1;
    nextCycle();
    rst = 0;
    #3;
    check("rr bus_req", 32'(bus.req), 0);
    check("rr addr_ok", 32'(data.addr_ok), 1);
    check("rr data_ok", 32'(data.data_ok), 0);
    check("rr rdata cleared", data.rdata, 0);
    n = 0;
    repeat (6) begin
      nextCycle();
      #3;
      if (bus.req) n++;
    end
    check("rr fifo emptied", 32'(n), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
